// File: rtl/gbm_evt_pkg.sv
// Shared types for the Game Boy note-event path: the event record, the
// arbiter state encoding and the event source codes.
package gbm_evt_pkg;

    // One note event as seen by the per-channel register writer.
    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [3:0] vel;
        logic [8:0] pb;
    } note_evt_t;

    localparam int EVT_W = $bits(note_evt_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam logic SRC_LIVE = 1'b0;
    localparam logic SRC_ECHO = 1'b1;

endpackage

// File: rtl/echo_event_arb_fifo.sv
// evt_fifo: small show-ahead synchronous FIFO of note events. dout is the
// head entry whenever empty is low, so a pop consumes the word already on
// dout. A push into a full FIFO is accepted only when a pop frees a slot in
// the same cycle. flush empties the FIFO and overrides push and pop.
module evt_fifo
    import gbm_evt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  note_evt_t din,
    output note_evt_t dout,
    output logic      empty,
    output logic      full
);
    localparam int AW = $clog2(DEPTH);

    note_evt_t       r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write.
    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/echo_event_arb.sv
// echo_event_arb: merges the live MIDI event stream and the echo generator's
// change events for one voice channel. Live events win; echo events wait in
// a FIFO. Issued events are one-cycle strobes spaced at least GAP+1 cycles
// apart so the downstream register sequencer finishes each write in time.
module echo_event_arb
    import gbm_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       live_valid,
    input  logic       live_on,
    input  logic [6:0] live_note,
    input  logic [3:0] live_vel,
    input  logic [8:0] live_pb,
    input  logic       echo_en,
    input  logic       echo_on,
    input  logic [6:0] echo_note,
    input  logic [3:0] echo_vel,
    input  logic [8:0] echo_pb,
    output logic       out_valid,
    output logic       out_on,
    output logic [6:0] out_note,
    output logic [3:0] out_vel,
    output logic [8:0] out_pb,
    output logic       out_src,
    output logic       busy,
    output logic       ovf
);
    localparam int            CW       = $clog2(GAP);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 2);

    note_evt_t     w_live_evt;
    note_evt_t     w_echo_evt;
    note_evt_t     w_fifo_dout;
    note_evt_t     r_live_evt;
    note_evt_t     r_snap;
    note_evt_t     r_out_evt;
    logic          r_live_pend;
    logic          r_out_src;
    logic          r_ovf;
    logic          w_echo_chg;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_load_live;
    logic          w_load_echo;
    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [CW-1:0] r_gap_cnt;

    assign w_live_evt = '{on: live_on, note: live_note, vel: live_vel, pb: live_pb};
    assign w_echo_evt = '{on: echo_on, note: echo_note, vel: echo_vel, pb: echo_pb};

    // The echo generator holds its outputs, so any difference from the last
    // sampled value is one new echo event.
    assign w_echo_chg = (w_echo_evt != r_snap);
    assign w_push     = en && echo_en && w_echo_chg;
    assign w_pop      = en && w_load_echo;
    assign w_flush    = en && !echo_en;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_echo_evt),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    // Live hold register: a newer live event replaces an unissued one, and a
    // capture in the same cycle as the FSM takes the old one keeps pend set.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live_evt  <= '0;
            r_live_pend <= 1'b0;
        end else if (en) begin
            if (live_valid) begin
                r_live_evt  <= w_live_evt;
                r_live_pend <= 1'b1;
            end else if (w_load_live) begin
                r_live_pend <= 1'b0;
            end
        end
    end

    // Echo snapshot tracks the inputs on every enabled cycle; ovf is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= '0;
            r_ovf  <= 1'b0;
        end else if (en) begin
            r_snap <= w_echo_evt;
            if (w_push && w_fifo_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Next-state decode: pick live first, then echo, while idle.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load_live = 1'b0;
        w_load_echo = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_live_pend) begin
                    w_load_live = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else if (echo_en && !w_fifo_empty) begin
                    w_load_echo = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_GAP;
            ST_GAP:   if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and gap counter; both freeze while en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
        end else if (en) begin
            r_state <= w_state_nxt;
            if (r_state == ST_ISSUE) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - CW'(1);
            end
        end
    end

    // Output registers load on the idle-to-issue transition only, so the
    // fields change exactly when the strobe rises and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_evt <= '0;
            r_out_src <= SRC_LIVE;
        end else if (en) begin
            if (w_load_live) begin
                r_out_evt <= r_live_evt;
                r_out_src <= SRC_LIVE;
            end else if (w_load_echo) begin
                r_out_evt <= w_fifo_dout;
                r_out_src <= SRC_ECHO;
            end
        end
    end

    assign out_valid = en && (r_state == ST_ISSUE);
    assign out_on    = r_out_evt.on;
    assign out_note  = r_out_evt.note;
    assign out_vel   = r_out_evt.vel;
    assign out_pb    = r_out_evt.pb;
    assign out_src   = r_out_src;
    assign busy      = (r_state != ST_IDLE) || r_live_pend || !w_fifo_empty;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_echo_event_arb.sv
// Bench for echo_event_arb: a directed table, hand-written multi-cycle
// sequences and a randomized phase, all checked each cycle against an
// event-level model (pending live slot, echo queue, earliest-next-strobe time).
module tb_echo_event_arb;
    import gbm_evt_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;

    logic       clk;
    logic       reset;
    logic       en;
    logic       live_valid;
    logic       live_on;
    logic [6:0] live_note;
    logic [3:0] live_vel;
    logic [8:0] live_pb;
    logic       echo_en;
    logic       echo_on;
    logic [6:0] echo_note;
    logic [3:0] echo_vel;
    logic [8:0] echo_pb;
    logic       out_valid;
    logic       out_on;
    logic [6:0] out_note;
    logic [3:0] out_vel;
    logic [8:0] out_pb;
    logic       out_src;
    logic       busy;
    logic       ovf;

    echo_event_arb #(
        .FIFO_DEPTH (DEPTH),
        .GAP        (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .live_valid (live_valid),
        .live_on    (live_on),
        .live_note  (live_note),
        .live_vel   (live_vel),
        .live_pb    (live_pb),
        .echo_en    (echo_en),
        .echo_on    (echo_on),
        .echo_note  (echo_note),
        .echo_vel   (echo_vel),
        .echo_pb    (echo_pb),
        .out_valid  (out_valid),
        .out_on     (out_on),
        .out_note   (out_note),
        .out_vel    (out_vel),
        .out_pb     (out_pb),
        .out_src    (out_src),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc_n, act, exp);
        end
    endtask

    // ---------------- reference model (enabled-cycle time) ----------------
    typedef struct packed {
        logic      src;
        note_evt_t ev;
    } rec_t;

    int        t;
    int        strobe_at;
    int        last_strobe;
    bit        has_last;
    bit        m_lp;
    note_evt_t m_lev;
    note_evt_t m_q[$];
    note_evt_t m_snap;
    bit        m_ovf;
    note_evt_t m_out;
    bit        m_src;
    rec_t      got_q[$];
    int        got_c[$];

    function automatic void model_reset();
        t = 0; strobe_at = -1; last_strobe = 0; has_last = 0;
        m_lp = 0; m_lev = '0; m_q.delete(); m_snap = '0;
        m_ovf = 0; m_out = '0; m_src = 0;
    endfunction

    // Compare this cycle's outputs, log strobes, then advance the model with
    // the inputs the DUT will sample at the coming edge.
    task automatic model_cycle();
        bit        exp_v;
        bit        exp_busy;
        bit        idle;
        note_evt_t ev_in;
        exp_v    = en && (strobe_at == t);
        exp_busy = (strobe_at == t) || (has_last && t < last_strobe + GAP) ||
                   m_lp || (m_q.size() != 0);
        check("valid",  32'(out_valid), 32'(exp_v));
        check("fields", 32'({out_on, out_note, out_vel, out_pb}), 32'(m_out));
        check("src",    32'(out_src), 32'(m_src));
        check("busy",   32'(busy), 32'(exp_busy));
        check("ovf",    32'(ovf), 32'(m_ovf));
        if (out_valid) begin
            got_q.push_back('{src: out_src, ev: '{on: out_on, note: out_note, vel: out_vel, pb: out_pb}});
            got_c.push_back(cyc_n);
        end
        cyc_n++;
        if (en) begin
            idle = (strobe_at != t) && (!has_last || t >= last_strobe + GAP);
            if (strobe_at == t) begin
                has_last    = 1;
                last_strobe = t;
            end
            if (idle) begin
                if (m_lp) begin
                    m_out = m_lev; m_src = 0; m_lp = 0; strobe_at = t + 1;
                end else if (echo_en && m_q.size() != 0) begin
                    m_out = m_q.pop_front(); m_src = 1; strobe_at = t + 1;
                end
            end
            if (live_valid) begin
                m_lp  = 1;
                m_lev = '{on: live_on, note: live_note, vel: live_vel, pb: live_pb};
            end
            ev_in = '{on: echo_on, note: echo_note, vel: echo_vel, pb: echo_pb};
            if (!echo_en) begin
                m_q.delete();
            end else if (ev_in != m_snap) begin
                if (m_q.size() < DEPTH) m_q.push_back(ev_in);
                else m_ovf = 1;
            end
            m_snap = ev_in;
            t++;
        end
    endtask

    // One clock: called at posedge+1 with inputs already driven.
    task automatic cyc();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic live(input logic [6:0] note);
        live_valid = 1'b1;
        {live_on, live_note, live_vel, live_pb} = {1'b1, note, 4'd7, 9'd100};
        cyc();
        live_valid = 1'b0;
    endtask

    task automatic echo_set(input logic [6:0] note);
        {echo_on, echo_note, echo_vel, echo_pb} = {1'b1, note, 4'd3, 9'd0};
        cyc();
    endtask

    // Asynchronous reset mid-cycle, outputs checked while it is held.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_fields", 32'({out_on, out_note, out_vel, out_pb}), 32'd0);
        check("rst_src",    32'(out_src), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_ovf",    32'(ovf), 32'd0);
        live_valid = 1'b0;
        {echo_on, echo_note, echo_vel, echo_pb} = '0;
        echo_en = 1'b1;
        en      = 1'b1;
        model_reset();
        got_q.delete();
        got_c.delete();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         lv;
        note_evt_t  lev;
        note_evt_t  eev;
        bit         xv;
        bit         xsrc;
        logic [6:0] xnote;
        bit         xbusy;
    } vec_t;

    localparam int NT = 62;
    vec_t tbl[NT];

    initial begin
        for (int i = 0; i < NT; i++) begin
            tbl[i].lv    = 0;
            tbl[i].lev   = '0;
            tbl[i].eev   = (i >= 40) ? note_evt_t'({1'b0, 7'd65, 4'd10, 9'd0}) :
                           (i >= 19) ? note_evt_t'({1'b0, 7'd64, 4'd10, 9'd0}) : '0;
            tbl[i].xv    = 0;
            tbl[i].xsrc  = 0;
            tbl[i].xnote = '0;
            tbl[i].xbusy = (i >= 1 && i <= 17) || (i >= 20 && i <= 36) || (i >= 41);
        end
        tbl[0].lv  = 1; tbl[0].lev  = '{on: 1'b1, note: 7'd60, vel: 4'd12, pb: 9'd256};
        tbl[40].lv = 1; tbl[40].lev = '{on: 1'b1, note: 7'd70, vel: 4'd5,  pb: 9'd3};
        tbl[2].xv  = 1; tbl[2].xsrc  = 0; tbl[2].xnote  = 7'd60;
        tbl[21].xv = 1; tbl[21].xsrc = 1; tbl[21].xnote = 7'd64;
        tbl[42].xv = 1; tbl[42].xsrc = 0; tbl[42].xnote = 7'd70;
        tbl[59].xv = 1; tbl[59].xsrc = 1; tbl[59].xnote = 7'd65;

        reset = 1'b1; en = 1'b1; live_valid = 1'b0; echo_en = 1'b1;
        {live_on, live_note, live_vel, live_pb} = '0;
        {echo_on, echo_note, echo_vel, echo_pb} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < NT; i++) begin
            live_valid = tbl[i].lv;
            {live_on, live_note, live_vel, live_pb} = tbl[i].lev;
            {echo_on, echo_note, echo_vel, echo_pb} = tbl[i].eev;
            @(negedge clk);
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].xv));
            check("tbl_busy",  32'(busy), 32'(tbl[i].xbusy));
            if (tbl[i].xv) begin
                check("tbl_src",  32'(out_src), 32'(tbl[i].xsrc));
                check("tbl_note", 32'(out_note), 32'(tbl[i].xnote));
            end
            model_cycle();
            @(posedge clk);
            #1;
        end
        live_valid = 1'b0;

        // Held echo values must not re-trigger.
        got_q.delete();
        idle_n(100);
        check("hold_no_strobe", 32'(got_q.size()), 32'd0);

        // Six echo changes while blocked in GAP: four queue, two drop.
        do_reset();
        live(7'd10);
        idle_n(2);
        for (int k = 0; k < 6; k++) echo_set(7'(20 + k));
        idle_n(5 * (GAP + 1));
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("ovf_count", 32'(got_q.size()), 32'd5);
        for (int k = 1; k < got_q.size(); k++) begin
            check("ovf_src",   32'(got_q[k].src), 32'd1);
            check("ovf_order", 32'(got_q[k].ev.note), 32'(20 + k - 1));
            check("ovf_space", 32'(got_c[k] - got_c[k-1]), 32'(GAP + 1));
        end

        // Two live strobes during GAP: latest wins.
        do_reset();
        live(7'd30);
        idle_n(2);
        live(7'd31);
        idle_n(2);
        live(7'd32);
        idle_n(40);
        check("live_ovr_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("live_ovr_note", 32'(got_q[1].ev.note), 32'd32);
            check("live_ovr_src",  32'(got_q[1].src), 32'd0);
        end

        // echo_en dropped with three echoes queued: nothing echo is issued.
        do_reset();
        live(7'd40);
        idle_n(2);
        echo_set(7'd50);
        echo_set(7'd51);
        echo_set(7'd52);
        echo_en = 1'b0;
        idle_n(60);
        check("flush_count", 32'(got_q.size()), 32'd1);
        echo_en = 1'b1;
        idle_n(5);

        // Reset in GAP with echoes queued: nothing comes out afterwards.
        do_reset();
        live(7'd41);
        idle_n(2);
        echo_set(7'd60);
        echo_set(7'd61);
        do_reset();
        idle_n(40);
        check("rst_gap_none", 32'(got_q.size()), 32'd0);

        // en low across ISSUE; echo change during en=0 seen on resume.
        do_reset();
        live(7'd42);
        idle_n(1);
        en = 1'b0;
        echo_set(7'd70);
        cyc();
        en = 1'b1;
        idle_n(40);
        check("en_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("en_live_note", 32'(got_q[0].ev.note), 32'd42);
            check("en_echo_src",  32'(got_q[1].src), 32'd1);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            en         = ($urandom_range(0, 15) != 0);
            live_valid = ($urandom_range(0, 19) == 0);
            {live_on, live_note, live_vel, live_pb} = 21'($urandom);
            if ($urandom_range(0, 7) == 0)
                {echo_on, echo_note, echo_vel, echo_pb} = 21'($urandom);
            if ($urandom_range(0, 199) == 0) echo_en = ~echo_en;
            if ($urandom_range(0, 1499) == 0) do_reset();
            else cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/echo_event_arb.md
# echo_event_arb

Arbitrates note events for one Game Boy voice channel between the live MIDI path and the delayed echo path produced by the echo generator. Live events take priority. Echo events are queued in a small FIFO. Output events are issued as one-cycle strobes with a guaranteed minimum spacing, so the downstream channel register writer always finishes one event before the next arrives. The block sits between the MIDI note decoder / echo generator pair and the per-channel sound register sequencer.

## Interface
Parameters:
- FIFO_DEPTH, 4, echo queue entries; power of 2, at least 2.
- GAP, 16, minimum cycles from one out_valid strobe to the next; at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  clock enable for all state
- live_valid  in  1  one-cycle strobe: live event present
- live_on / live_note / live_vel / live_pb  in  1/7/4/9  live event fields
- echo_en  in  1  echo feature enable
- echo_on / echo_note / echo_vel / echo_pb  in  1/7/4/9  held echo-generator outputs (level, not strobe)
- out_valid  out  1  one-cycle event strobe
- out_on / out_note / out_vel / out_pb  out  1/7/4/9  issued event fields; held until the next strobe
- out_src  out  1  source of the issued event: 0 = live, 1 = echo
- busy  out  1  FSM not in IDLE, or any event pending
- ovf  out  1  sticky: an echo event was dropped

## Operation
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, live hold register empty, last-echo snapshot all 0.
- **Live capture:** live_valid=1 loads the live hold register and sets live_pend.
  - A new live_valid while live_pend is set overwrites the held event (latest wins). No flag is raised.
- **Echo detect:** an echo event occurs when any of {echo_on, echo_note, echo_vel, echo_pb} differs from the snapshot.
  - The snapshot is updated on every en cycle, regardless of echo_en.
  - If echo_en=1, the event is pushed to the FIFO.
  - If echo_en=0, the event is discarded and the FIFO is flushed (and held empty).
- **FIFO:**
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and ovf is set; only reset clears ovf.
- **FSM states: IDLE, ISSUE, GAP.**
  - IDLE: if live_pend, load the live event into the output regs with out_src=0, clear live_pend, go to ISSUE.
  - IDLE: else if the FIFO is not empty, pop into the output regs with out_src=1, go to ISSUE.
  - ISSUE: out_valid=1 for exactly this cycle; load gap counter = GAP-2; go to GAP.
  - GAP: decrement the counter; at 0 go to IDLE.
- Live and echo arriving together: both are captured, and live is issued first.
- **en=0:** no captures, no FSM or counter change, no snapshot update; out_valid is forced to 0.
  - Echo changes that occur while en=0 are detected on the first en=1 cycle.
  - If en falls while the FSM is in ISSUE, the strobe is suppressed for those cycles and reappears when en returns.
- Reset asserted mid-operation: all state returns to reset values immediately; pending and queued events are lost.

## Timing
- Live path: live_valid in cycle N with the FSM in IDLE and nothing pending gives out_valid in cycle N+2.
- Echo path: echo change in cycle N, FIFO empty, FSM in IDLE gives out_valid in cycle N+2. Live pending delays this by GAP+1.
- Strobe spacing: out_valid in cycle M means the next out_valid is no earlier than M+GAP+1. Back-to-back pending events are issued exactly GAP+1 cycles apart.
- out_* fields change only in the cycle out_valid rises.
- busy is combinational from state, live_pend and FIFO-empty.

## Structure
- Shared package gbm_evt_pkg:
  - note_evt_t: packed struct {on, note[6:0], vel[3:0], pb[8:0]}, 21 bits.
  - arb_state_t: enum {IDLE, ISSUE, GAP}.
  - SRC_LIVE / SRC_ECHO constants.
- One sub-module, evt_fifo: synchronous FIFO of note_evt_t.
  - Parameter DEPTH.
  - Ports: push, pop, din, dout, empty, full, flush.
  - Pop data is valid in the same cycle as pop (show-ahead).
- Top-level contents: live hold register, echo snapshot and compare, FSM, gap counter, output registers.

## Test plan
- Reset, then live_valid with on=1, note=60, vel=12, pb=256 → out_valid in cycle N+2 with those fields and out_src=0; busy then drops after GAP+1 cycles.
- Echo fields step to note=64, vel=10 with echo_en=1 → out_valid in cycle N+2, out_src=1. The same values held for 100 cycles produce no further strobe.
- Live strobe and echo change in the same cycle, GAP=16 → live issued at N+2, echo issued at N+19.
- Echo changes in 6 consecutive cycles with FIFO_DEPTH=4 and the FSM blocked in GAP → 4 queued plus at most 1 popped; ovf=1; queued echoes are issued in order, GAP+1 cycles apart.
- Two live strobes 3 cycles apart while the FSM is in GAP → only the second event is issued.
- echo_en=0 with 3 events queued → FIFO flushed, no echo strobe.
- Reset asserted during GAP with events queued → all outputs 0, nothing issued after reset release.
